// File: rtl/seg7_scan_decoder_if.sv
// Observed 7-segment scan bus and the decoded readback it produces.
// master drives the display bus and watches results; slave is the decoder.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [0:6]              seg_n;
    logic [NUM_DIGITS-1:0]   digit_sel_n;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   valid;
    logic [NUM_DIGITS-1:0]   err;
    logic                    update;
    logic [2:0]              upd_digit;
    logic                    frame_done;

    modport master (
        output seg_n, digit_sel_n,
        input  hex_out, valid, err, update, upd_digit, frame_done
    );

    modport slave (
        input  seg_n, digit_sel_n,
        output hex_out, valid, err, update, upd_digit, frame_done
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit hex nibbles from a multiplexed active-low 7-segment bus.
// Commit lands STABLE_CYCLES-1 edges after the first sampling edge; no backpressure.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seg7_scan_decoder_if.slave bus_if
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        SEEK,
        TRACK,
        LOCKED
    } state_e;

    state_e                  state_q, state_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic [RUN_W:0]          run_inc;
    logic [NUM_DIGITS-1:0]   prev_sel_q;
    logic [0:6]              prev_seg_q;

    logic [4*NUM_DIGITS-1:0] hex_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic                    update_q;
    logic [2:0]              upd_digit_q;
    logic                    frame_done_q;

    logic [NUM_DIGITS-1:0]   sel_hot;
    logic                    legal;
    logic                    same;
    logic                    commit;
    logic [2:0]              idx;
    logic [5:0]              dec;
    logic                    dec_hex;
    logic                    dec_blank;
    logic [3:0]              dec_nib;

    // Result layout: {is_hex, is_blank, nibble}.
    function automatic logic [5:0] decode_seg(input logic [0:6] seg);
        logic [5:0] r;
        case (seg)
            7'b0000001: r = {2'b10, 4'h0};
            7'b1001111: r = {2'b10, 4'h1};
            7'b0010010: r = {2'b10, 4'h2};
            7'b0000110: r = {2'b10, 4'h3};
            7'b1001100: r = {2'b10, 4'h4};
            7'b0100100: r = {2'b10, 4'h5};
            7'b0100000: r = {2'b10, 4'h6};
            7'b0001111: r = {2'b10, 4'h7};
            7'b0000000: r = {2'b10, 4'h8};
            7'b0000100: r = {2'b10, 4'h9};
            7'b0001000: r = {2'b10, 4'hA};
            7'b1100000: r = {2'b10, 4'hB};
            7'b0110001: r = {2'b10, 4'hC};
            7'b1000010: r = {2'b10, 4'hD};
            7'b0110000: r = {2'b10, 4'hE};
            7'b0111000: r = {2'b10, 4'hF};
            7'b1111111: r = {2'b01, 4'h0};
            default:    r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    always_comb begin
        sel_hot   = ~bus_if.digit_sel_n;
        legal     = ($countones(sel_hot) == 1);
        same      = (bus_if.digit_sel_n == prev_sel_q) && (bus_if.seg_n == prev_seg_q);
        idx       = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_hot[i]) begin
                idx = 3'(i);
            end
        end
        dec       = decode_seg(bus_if.seg_n);
        dec_hex   = dec[5];
        dec_blank = dec[4];
        dec_nib   = dec[3:0];
        run_inc   = {1'b0, run_q} + (RUN_W + 1)'(1);
    end

    // Run tracking: one commit per maximal stretch of identical legal samples.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        commit  = 1'b0;
        case (state_q)
            SEEK: begin
                if (legal) begin
                    run_d = RUN_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        commit  = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        state_d = TRACK;
                    end
                end
            end
            TRACK: begin
                if (!legal) begin
                    run_d   = '0;
                    state_d = SEEK;
                end else if (same) begin
                    if (run_inc >= {1'b0, RUN_MAX}) begin
                        run_d   = RUN_MAX;
                        commit  = 1'b1;
                        state_d = LOCKED;
                    end else begin
                        run_d = run_inc[RUN_W-1:0];
                    end
                end else begin
                    run_d = RUN_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        commit  = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!legal) begin
                    run_d   = '0;
                    state_d = SEEK;
                end else if (!same) begin
                    run_d = RUN_W'(1);
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = TRACK;
                    end
                end
            end
            default: begin
                run_d   = '0;
                state_d = SEEK;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SEEK;
            run_q      <= '0;
            prev_sel_q <= '1;
            prev_seg_q <= '1;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            prev_sel_q <= bus_if.digit_sel_n;
            prev_seg_q <= bus_if.seg_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hex_q        <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            seen_q       <= '0;
            update_q     <= 1'b0;
            upd_digit_q  <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            update_q     <= commit;
            frame_done_q <= 1'b0;
            if (commit) begin
                upd_digit_q <= idx;
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (sel_hot[d]) begin
                        if (dec_hex) begin
                            hex_q[4*d +: 4] <= dec_nib;
                            valid_q[d]      <= 1'b1;
                            err_q[d]        <= 1'b0;
                        end else if (dec_blank) begin
                            valid_q[d] <= 1'b0;
                            err_q[d]   <= 1'b0;
                        end else begin
                            valid_q[d] <= 1'b0;
                            err_q[d]   <= 1'b1;
                        end
                    end
                end
                // The completing commit opens a fresh, empty frame.
                if ((seen_q | sel_hot) == '1) begin
                    seen_q       <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    seen_q <= seen_q | sel_hot;
                end
            end
        end
    end

    assign bus_if.hex_out    = hex_q;
    assign bus_if.valid      = valid_q;
    assign bus_if.err        = err_q;
    assign bus_if.update     = update_q;
    assign bus_if.upd_digit  = upd_digit_q;
    assign bus_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised and directed stimulus for seg7_scan_decoder against a run-length reference model.
module tb_seg7_scan_decoder;
    localparam int N = 4;
    localparam int S = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    seg7_scan_decoder_if #(.NUM_DIGITS(N)) bus_if ();

    seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus_if (bus_if.slave)
    );

    int checks = 0;
    int passes = 0;

    logic [0:6]   tbl [16];
    logic [3:0]   m_hex [N];
    logic [N-1:0] m_valid, m_err, m_seen, m_psel;
    logic [0:6]   m_pseg;
    logic         m_update, m_frame;
    int           m_upd, m_cnt;
    int           cyc = 0, n_updates = 0, n_frames = 0, last_upd_cyc = 0, last_frame_dig = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: a commit happens when a run of identical legal samples reaches length S.
    task automatic model_edge();
        int zeros, d, v;
        logic same;
        cyc++;
        m_update = 1'b0;
        m_frame  = 1'b0;
        if (rst_i) begin
            for (int i = 0; i < N; i++) m_hex[i] = 4'h0;
            m_valid = '0; m_err = '0; m_seen = '0; m_upd = 0; m_cnt = 0;
            return;
        end
        zeros = 0; d = 0;
        for (int i = 0; i < N; i++) begin
            if (!bus_if.digit_sel_n[i]) begin zeros++; d = i; end
        end
        same = (bus_if.digit_sel_n == m_psel) && (bus_if.seg_n == m_pseg);
        if (zeros != 1)               m_cnt = 0;
        else if (m_cnt > 0 && same)   m_cnt = (m_cnt > S) ? m_cnt : m_cnt + 1;
        else                          m_cnt = 1;
        m_psel = bus_if.digit_sel_n;
        m_pseg = bus_if.seg_n;
        if (zeros == 1 && m_cnt == S) begin
            v = -1;
            for (int k = 0; k < 16; k++) if (tbl[k] == bus_if.seg_n) v = k;
            if (v >= 0) begin
                m_hex[d] = v[3:0]; m_valid[d] = 1'b1; m_err[d] = 1'b0;
            end else if (bus_if.seg_n == 7'b1111111) begin
                m_valid[d] = 1'b0; m_err[d] = 1'b0;
            end else begin
                m_valid[d] = 1'b0; m_err[d] = 1'b1;
            end
            m_update = 1'b1; m_upd = d; n_updates++; last_upd_cyc = cyc;
            m_seen[d] = 1'b1;
            if (&m_seen) begin
                m_seen = '0; m_frame = 1'b1; n_frames++; last_frame_dig = d;
            end
        end
    endtask

    task automatic check_outputs();
        logic [4*N-1:0] exp_hex;
        for (int i = 0; i < N; i++) exp_hex[4*i +: 4] = m_hex[i];
        chk("update",     bus_if.update,     m_update);
        chk("frame_done", bus_if.frame_done, m_frame);
        chk("hex_out",    bus_if.hex_out,    exp_hex);
        chk("valid",      bus_if.valid,      m_valid);
        chk("err",        bus_if.err,        m_err);
        if (m_update) chk("upd_digit", bus_if.upd_digit, m_upd);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    task automatic drive(input logic [N-1:0] sel, input logic [0:6] seg, input int n);
        bus_if.digit_sel_n = sel;
        bus_if.seg_n       = seg;
        step(n);
    endtask

    initial begin
        int n0, f0, start, r;
        logic [N-1:0] sel;
        logic [0:6]   seg;

        tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010; tbl[3]  = 7'b0000110;
        tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100; tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111;
        tbl[8]  = 7'b0000000; tbl[9]  = 7'b0000100; tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
        tbl[12] = 7'b0110001; tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
        m_psel = '1; m_pseg = '1; m_cnt = 0;

        bus_if.digit_sel_n = '1;
        bus_if.seg_n       = '1;
        rst_i = 1'b1;
        step(2);
        chk("reset hex_out", bus_if.hex_out, 0);
        chk("reset valid",   bus_if.valid,   0);
        chk("reset err",     bus_if.err,     0);
        rst_i = 1'b0;

        // Single digit "2": one update, three cycles after the first sampling edge.
        n0 = n_updates; start = cyc + 1;
        drive(4'b1110, 7'b0010010, 10);
        chk("t1 update count", n_updates - n0, 1);
        chk("t1 latency", last_upd_cyc - start, 3);
        chk("t1 hex0", bus_if.hex_out[3:0], 4'h2);
        chk("t1 valid", bus_if.valid, 4'b0001);
        chk("t1 err", bus_if.err, 4'b0000);

        // Scan 1, A, b, F across digits 0..3.
        n0 = n_updates; f0 = n_frames;
        drive(4'b1110, 7'b1001111, 6);
        drive(4'b1101, 7'b0001000, 6);
        drive(4'b1011, 7'b1100000, 6);
        drive(4'b0111, 7'b0111000, 6);
        chk("t2 update count", n_updates - n0, 4);
        chk("t2 frame count", n_frames - f0, 1);
        chk("t2 frame digit", last_frame_dig, 3);
        chk("t2 hex_out", bus_if.hex_out, 16'hFBA1);
        chk("t2 valid", bus_if.valid, 4'b1111);

        // Unrecognised pattern then blank on digit 1.
        drive(4'b1101, 7'b1010101, 6);
        chk("t3 err", bus_if.err, 4'b0010);
        chk("t3 valid", bus_if.valid, 4'b1101);
        chk("t3 hex1 kept", bus_if.hex_out[7:4], 4'hA);
        drive(4'b1101, 7'b1111111, 6);
        chk("t3 blank err", bus_if.err, 4'b0000);
        chk("t3 blank valid", bus_if.valid, 4'b1101);

        // Glitching g segment on digit 2 never forms a full run.
        n0 = n_updates;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1011, 7'b0000000, 2);
            drive(4'b1011, 7'b0000001, 2);
        end
        chk("t4 no update while toggling", n_updates - n0, 0);
        drive(4'b1011, 7'b0000000, 6);
        chk("t4 update after hold", n_updates - n0, 1);
        chk("t4 hex2", bus_if.hex_out[11:8], 4'h8);

        // Illegal selects, then a legal value restarts its run.
        n0 = n_updates;
        drive(4'b1100, 7'b0000110, 10);
        drive(4'b1111, 7'b0000110, 10);
        chk("t5 no update on illegal select", n_updates - n0, 0);
        start = cyc + 1;
        drive(4'b1011, 7'b0000000, 6);
        chk("t5 restart latency", last_upd_cyc - start, 3);

        // Reset on the edge where the commit would have landed.
        n0 = n_updates;
        drive(4'b1110, 7'b0100100, 3);
        rst_i = 1'b1;
        step(1);
        chk("t6 reset update", bus_if.update, 0);
        chk("t6 reset hex_out", bus_if.hex_out, 0);
        chk("t6 reset valid", bus_if.valid, 0);
        rst_i = 1'b0;
        step(3);
        chk("t6 no early commit", n_updates - n0, 0);
        step(1);
        chk("t6 fresh run commit", n_updates - n0, 1);
        chk("t6 hex0", bus_if.hex_out[3:0], 4'h5);

        // Random scan traffic.
        for (int t = 0; t < 500; t++) begin
            sel = '1;
            sel[$urandom_range(0, N-1)] = 1'b0;
            if ($urandom_range(0, 9) == 0) sel = N'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)       seg = tbl[$urandom_range(0, 15)];
            else if (r == 7) seg = 7'b1111111;
            else             seg = 7'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst_i = 1'b1;
                step(1);
                rst_i = 1'b0;
            end
            drive(sel, seg, $urandom_range(1, 7));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Inverse of the board's hex-to-7-segment encoder: observes a multiplexed, active-low 7-segment display bus and recovers the hex nibble shown on each digit.
- Sits beside any display driver as a loopback checker and self-test readback path.
- Filters scan glitches with a stability counter and flags unrecognised patterns per digit.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits observed (1..8).
- STABLE_CYCLES, 4, consecutive identical legal samples required before a commit (>=1).

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- seg_n  input  [0:6]  active-low segments; index 0=a (top), 1=b, 2=c, 3=d (bottom), 4=e, 5=f, 6=g (middle).
- digit_sel_n  input  NUM_DIGITS  active-low digit enables; legal only when exactly one bit is 0.
- hex_out  output  4*NUM_DIGITS  decoded nibble of digit d at [4d+3:4d].
- valid  output  NUM_DIGITS  digit d holds a recognised hex value.
- err  output  NUM_DIGITS  digit d's last commit was an unrecognised, non-blank pattern.
- update  output  1  one-cycle pulse: a commit occurred at the previous edge.
- upd_digit  output  3  index of the digit committed (meaningful while update=1).
- frame_done  output  1  one-cycle pulse: every digit has committed since the last frame_done or Reset.

Behaviour:
- Reset, including mid-operation, has priority over everything. It zeroes hex_out, valid, err, update, upd_digit, frame_done, the run counter and the seen mask. FSM returns to SEEK.
- Decode table, seg_n written as bits 0..6 left to right:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Blank=1111111. Any other pattern is illegal.
- Sample = (digit_sel_n, seg_n) captured at each edge. A sample is legal iff digit_sel_n has exactly one 0.
- FSM states:
  - SEEK: no run in progress. A legal sample sets run=1 and moves to TRACK. With STABLE_CYCLES=1, it commits immediately and moves to LOCKED.
  - TRACK: a sample identical to the previous one increments run; when run reaches STABLE_CYCLES, commit and move to LOCKED. A different legal sample restarts run at 1 and stays in TRACK. An illegal sample returns to SEEK with run=0.
  - LOCKED: identical samples do nothing; exactly one commit per stable run. A different legal sample sets run=1 and moves to TRACK (or commits again at once if STABLE_CYCLES=1). An illegal sample moves to SEEK.
- Commit timing: with inputs constant from before edge k, the commit registers at edge k+STABLE_CYCLES-1.
- Commit to digit d (the index of the 0 bit):
  - Recognised value: hex_out[d]=value, valid[d]=1, err[d]=0.
  - Blank: valid[d]=0, err[d]=0, hex_out[d] unchanged.
  - Illegal pattern: err[d]=1, valid[d]=0, hex_out[d] unchanged.
  - In all cases update=1 and upd_digit=d for the following cycle; other digits are untouched.
- Seen mask: a commit sets seen[d]. When the commit makes the mask all-ones:
  - frame_done pulses in the same cycle as that update;
  - the mask clears to zero (the completing commit does not count toward the next frame).
- update and frame_done are never high for more than one consecutive cycle per commit.
- The run counter saturates at STABLE_CYCLES and never wraps.

Test Plan:
- Reset, then hold digit_sel_n=1110 and seg_n=0010010 for 10 cycles -> single update, 3 cycles after the first sampling edge; upd_digit=0, hex_out[3:0]=2, valid=0001, err=0000.
- Scan digits 0..3 showing 1,A,b,F, each held 6 cycles -> four updates, hex_out=16'hFBA1, valid=1111. frame_done pulses with the digit-3 update only.
- Digit 1 shows 1010101 for 6 cycles -> err=0010, valid[1]=0, hex_out[7:4] keeps its prior value. A later blank (1111111) -> err[1]=0, valid[1]=0.
- Hold digit 2 showing 8 but toggle seg_n[6] every 2 cycles (run < 4), then hold -> no update during toggling; one update once 4 identical samples are seen.
- digit_sel_n=1100 or 1111 with any segments for 10 cycles -> no update, outputs unchanged. Then a legal value restarts the count from 1.
- Assert Reset at the cycle before a commit would occur -> no update, all outputs 0. Re-commit requires a full fresh run of 4 samples.
